// File: rtl/scanout_fetcher_if.sv
// Bundles the pixel-side FIFO port and the Avalon-MM read port of the scanout fetcher.
// Pure wiring: no storage, no latency.
// Backpressure is pixel_ready on the pixel side; the SRAM side has fixed timing and no waitrequest.
interface scanout_fetcher_if;
  // pixel pipeline side
  logic        frame_start;
  logic        pixel_ready;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        underflow;
  logic        frame_done;
  // Avalon-MM host side towards the SRAM controller
  logic [19:0] mm_address;
  logic        mm_read;
  logic [15:0] mm_readdata;
  logic        mm_write;
  logic [15:0] mm_writedata;

  // fetcher view
  modport master (
    input  frame_start, pixel_ready, mm_readdata,
    output pixel_data, pixel_valid, underflow, frame_done,
    output mm_address, mm_read, mm_write, mm_writedata
  );

  // environment view: pixel consumer plus SRAM controller
  modport slave (
    output frame_start, pixel_ready, mm_readdata,
    input  pixel_data, pixel_valid, underflow, frame_done,
    input  mm_address, mm_read, mm_write, mm_writedata
  );
endinterface

// File: rtl/scanout_fetcher.sv
// Streams FRAME_WORDS consecutive SRAM words from FB_BASE into a small FIFO for video scanout.
// Latency: each read takes 3 cycles (RD0..RD2); the word is pushed at the edge ending RD2 and is visible the next cycle.
// Backpressure: a read is only issued when the FIFO is guaranteed to have room for it; pixel_ready on empty sets underflow.
module scanout_fetcher #(
  parameter logic [19:0] FB_BASE     = 20'h00000,
  parameter int          FRAME_WORDS = 307200,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               reset,
  scanout_fetcher_if.master  bus
);

  localparam int CW = 21;                       // word counters must reach 2^20
  localparam int PW = $clog2(FIFO_DEPTH);       // FIFO pointer width
  localparam int NW = PW + 1;                   // FIFO occupancy width (0..FIFO_DEPTH)
  localparam logic [CW-1:0] FRAME_W = CW'(FRAME_WORDS);
  localparam logic [NW-1:0] DEPTH_W = NW'(FIFO_DEPTH);

  // Reject frames that run past the top of the 20-bit address space and illegal FIFO sizes.
  if ((FRAME_WORDS < 1) || ((int'(FB_BASE) + FRAME_WORDS) > 1048576) ||
      (FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
    $error("scanout_fetcher: illegal FB_BASE/FRAME_WORDS/FIFO_DEPTH combination");
  end

  typedef enum logic [1:0] {IDLE, RD0, RD1, RD2} state_t;

  state_t          state_q;
  logic            mm_read_q;
  logic [19:0]     mm_addr_q;
  logic [CW-1:0]   issued_q;     // reads started in the current frame
  logic [CW-1:0]   capt_q;       // words pushed into the FIFO in the current frame
  logic            stale_q;      // in-flight read was overtaken by frame_start
  logic            done_q;
  logic            underflow_q;

  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [NW-1:0]   cnt_q;
  logic [NW-1:0]   cnt_d;

  logic            push;
  logic            pop;
  logic            issue_ok;
  logic            start_rd;
  logic [CW-1:0]   capt_inc;

  // The edge ending RD2 is the capture edge; stale data and data racing a frame_start are dropped.
  assign push     = (state_q == RD2) && !stale_q && !bus.frame_start;
  // A pop coinciding with frame_start is ignored because the flush wins.
  assign pop      = bus.pixel_ready && (cnt_q != '0) && !bus.frame_start;
  assign capt_inc = capt_q + 1'b1;

  // Next FIFO occupancy, including this edge's push/pop, so a new read can reserve its slot safely.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.frame_start) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // A new read needs words left in the frame and a free slot once the current read has landed.
  // frame_start blocks issue for one edge so the rewound counters take effect first.
  assign issue_ok = !bus.frame_start && (issued_q < FRAME_W) && (cnt_d < DEPTH_W);
  assign start_rd = issue_ok && ((state_q == IDLE) || (state_q == RD2));

  // Read sequencer: 3-cycle transfers, address/strobe registered and held for the whole transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mm_read_q <= 1'b0;
      mm_addr_q <= FB_BASE;
      issued_q  <= '0;
      capt_q    <= '0;
      stale_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_q <= start_rd ? RD0 : IDLE;
        RD0:     state_q <= RD1;
        RD1:     state_q <= RD2;
        RD2:     state_q <= start_rd ? RD0 : IDLE;
        default: state_q <= IDLE;
      endcase

      if (start_rd) begin
        mm_read_q <= 1'b1;
        mm_addr_q <= FB_BASE + issued_q[19:0];
      end else if (state_q == RD2) begin
        mm_read_q <= 1'b0;
      end

      if (bus.frame_start) begin
        issued_q <= '0;
        capt_q   <= '0;
        done_q   <= 1'b0;
        // A transfer still in RD0/RD1 completes on the bus but its data must not land.
        stale_q  <= (state_q == RD0) || (state_q == RD1);
        if (state_q == IDLE) begin
          mm_addr_q <= FB_BASE;
        end
      end else begin
        if (start_rd) begin
          issued_q <= issued_q + 1'b1;
        end
        if (push) begin
          capt_q <= capt_inc;
          done_q <= (capt_inc == FRAME_W);
        end
        if (state_q == RD2) begin
          stale_q <= 1'b0;
        end
      end
    end
  end

  // FIFO storage; only written on a genuine capture, so an aborted transfer never lands.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.mm_readdata;
    end
  end

  // FIFO pointers, occupancy and sticky underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (bus.frame_start) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        underflow_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        if (bus.pixel_ready && (cnt_q == '0)) begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  // Fall-through head: valid in the same cycle as pixel_valid, forced to zero when empty.
  assign bus.pixel_valid  = (cnt_q != '0);
  assign bus.pixel_data   = (cnt_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
  assign bus.underflow    = underflow_q;
  assign bus.frame_done   = done_q;
  assign bus.mm_address   = mm_addr_q;
  assign bus.mm_read      = mm_read_q;
  assign bus.mm_write     = 1'b0;
  assign bus.mm_writedata = 16'h0000;

endmodule

// File: tb/tb_scanout_fetcher.sv
// Self-checking bench for scanout_fetcher: reset values, a hand-derived start-up table,
// multi-cycle corner sequences (frame end, frame_start mid-read, async reset mid-read) and random traffic
// checked against a transaction-level reference model.
module tb_scanout_fetcher;

  localparam logic [19:0] FB_BASE = 20'h00000;
  localparam int          FW      = 10;
  localparam int          DEPTH   = 4;

  logic clk;
  logic reset;

  scanout_fetcher_if bus ();

  scanout_fetcher #(
    .FB_BASE    (FB_BASE),
    .FRAME_WORDS(FW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a read is a 3-cycle countdown; the FIFO is a queue of expected words.
  int          m_left;     // cycles left in current read (0 = no read on the bus)
  int          m_idx;      // frame-relative index of the read on the bus
  int          m_issued;
  int          m_capt;
  bit          m_stale;
  bit          m_uf;
  bit          m_done;
  logic [15:0] m_q[$];

  function automatic logic [15:0] word_of(input int idx);
    logic [19:0] a;
    a = FB_BASE + 20'(idx);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic void model_reset();
    m_left = 0; m_idx = 0; m_issued = 0; m_capt = 0;
    m_stale = 0; m_uf = 0; m_done = 0;
    m_q.delete();
  endfunction

  function automatic void model_step(input bit fs, input bit pr);
    bit pop;
    bit ending;
    pop    = pr && (m_q.size() > 0) && !fs;
    ending = (m_left == 1);
    if (pr && m_q.size() == 0) m_uf = 1;
    if (pop) void'(m_q.pop_front());
    if (ending && !m_stale && !fs) begin
      m_q.push_back(word_of(m_idx));
      m_capt++;
    end
    if (m_left > 1 && fs) m_stale = 1;
    if (fs) begin
      m_q.delete();
      m_issued = 0; m_capt = 0; m_uf = 0;
    end
    m_done = (m_capt == FW);
    if (m_left > 1) begin
      m_left--;
    end else begin
      m_stale = 0;
      if (!fs && m_issued < FW && m_q.size() < DEPTH) begin
        m_left = 3; m_idx = m_issued; m_issued++;
      end else begin
        m_left = 0;
      end
    end
  endfunction

  // One clock cycle: drive inputs, compare against the model, advance model and clock.
  task automatic cycle(input logic fs, input logic pr);
    bus.frame_start = fs;
    bus.pixel_ready = pr;
    bus.mm_readdata = (m_left == 1) ? word_of(m_idx) : 16'hDEAD;
    #1;
    chk("m_read",  32'(bus.mm_read),    32'(m_left > 0));
    if (m_left > 0) chk("m_addr", 32'(bus.mm_address), 32'(FB_BASE + 20'(m_idx)));
    chk("m_valid", 32'(bus.pixel_valid), 32'(m_q.size() > 0));
    chk("m_data",  32'(bus.pixel_data),  32'((m_q.size() > 0) ? m_q[0] : 16'h0000));
    chk("m_uflow", 32'(bus.underflow),   32'(m_uf));
    chk("m_done",  32'(bus.frame_done),  32'(m_done));
    if (dut.push) chk("fifo_overflow", 32'((dut.cnt_q == DEPTH) && !dut.pop), 32'd0);
    model_step(fs, pr);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- start-up vector table ----------------
  typedef struct {
    logic        fs;
    logic        pr;
    logic        rd;
    logic [19:0] addr;
    logic        vld;
    logic [15:0] dat;
    logic        uf;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  function automatic void add(input logic pr, input logic rd, input logic [19:0] a,
                              input logic vld, input logic [15:0] d, input logic uf, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{1'b0, pr, rd, a, vld, d, uf});
  endfunction

  int n;
  int p;

  initial begin
    bus.frame_start = 1'b0;
    bus.pixel_ready = 1'b0;
    bus.mm_readdata = 16'hDEAD;
    reset = 1'b1;

    // cycle-by-cycle expectations from reset release, FIFO_DEPTH=4, FRAME_WORDS=10
    add(0, 0, 20'd0, 0, 16'h0000, 0, 1);   // c0 idle
    add(0, 1, 20'd0, 0, 16'h0000, 0, 3);   // c1-3 read 0
    add(0, 1, 20'd1, 1, 16'hA5A5, 0, 3);   // c4-6 read 1, first word visible
    add(0, 1, 20'd2, 1, 16'hA5A5, 0, 3);
    add(0, 1, 20'd3, 1, 16'hA5A5, 0, 3);
    add(0, 0, 20'd0, 1, 16'hA5A5, 0, 1);   // c13 FIFO full, fetch stalls
    add(1, 0, 20'd0, 1, 16'hA5A5, 0, 1);   // c14 pop one
    add(0, 1, 20'd4, 1, 16'hA5A4, 0, 3);   // c15-17 exactly one new read
    add(1, 0, 20'd0, 1, 16'hA5A4, 0, 1);   // c18 full again, pop
    add(1, 1, 20'd5, 1, 16'hA5A7, 0, 1);   // c19
    add(1, 1, 20'd5, 1, 16'hA5A6, 0, 1);   // c20
    add(1, 1, 20'd5, 1, 16'hA5A1, 0, 1);   // c21 pop together with push
    add(1, 1, 20'd6, 1, 16'hA5A0, 0, 1);   // c22
    add(1, 1, 20'd6, 0, 16'h0000, 0, 1);   // c23 empty, ready -> underflow
    add(0, 1, 20'd6, 0, 16'h0000, 1, 1);   // c24 sticky
    add(0, 1, 20'd7, 1, 16'hA5A3, 1, 1);   // c25

    @(negedge clk);
    @(negedge clk);
    chk("rst_read",  32'(bus.mm_read),      32'd0);
    chk("rst_addr",  32'(bus.mm_address),   32'(FB_BASE));
    chk("rst_valid", 32'(bus.pixel_valid),  32'd0);
    chk("rst_data",  32'(bus.pixel_data),   32'd0);
    chk("rst_uflow", 32'(bus.underflow),    32'd0);
    chk("rst_done",  32'(bus.frame_done),   32'd0);
    chk("rst_write", 32'(bus.mm_write),     32'd0);
    chk("rst_wdata", 32'(bus.mm_writedata), 32'd0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      chk("tbl_read",  32'(bus.mm_read),     32'(v.rd));
      if (v.rd) chk("tbl_addr", 32'(bus.mm_address), 32'(v.addr));
      chk("tbl_valid", 32'(bus.pixel_valid), 32'(v.vld));
      chk("tbl_data",  32'(bus.pixel_data),  32'(v.dat));
      chk("tbl_uflow", 32'(bus.underflow),   32'(v.uf));
      chk("tbl_done",  32'(bus.frame_done),  32'd0);
      cycle(v.fs, v.pr);
    end

    // frame completes with the consumer draining; fetch then stays idle
    n = 0;
    while (!bus.frame_done && n < 300) begin cycle(0, 1); n++; end
    chk("frame_done_reached", 32'(bus.frame_done), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("idle_after_done", 32'(bus.mm_read), 32'd0);
      cycle(0, 1);
    end

    // frame_start during RD1 of address 5
    cycle(1, 0);
    n = 0;
    while (!(m_left == 2 && m_issued == 6) && n < 200) begin cycle(0, 1); n++; end
    chk("reach_rd1_addr5", 32'(bus.mm_address), 32'd5);
    cycle(1, 1);
    chk("fs_hold_read", 32'(bus.mm_read),    32'd1);
    chk("fs_hold_addr", 32'(bus.mm_address), 32'd5);
    cycle(0, 0);
    chk("fs_next_read",  32'(bus.mm_read),     32'd1);
    chk("fs_next_addr",  32'(bus.mm_address),  32'(FB_BASE));
    chk("fs_fifo_empty", 32'(bus.pixel_valid), 32'd0);
    chk("fs_uflow_clr",  32'(bus.underflow),   32'd0);
    chk("fs_done_clr",   32'(bus.frame_done),  32'd0);
    for (int i = 0; i < 20; i++) cycle(0, 0);

    // asynchronous reset in the middle of RD1
    n = 0;
    while (!(m_left == 2) && n < 50) begin cycle(0, 1); n++; end
    chk("reach_rd1", 32'(bus.mm_read), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_read_drop",  32'(bus.mm_read),     32'd0);
    chk("arst_fifo_empty", 32'(bus.pixel_valid), 32'd0);
    bus.pixel_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(0, 0);
    chk("arst_restart_read", 32'(bus.mm_read),    32'd1);
    chk("arst_restart_addr", 32'(bus.mm_address), 32'(FB_BASE));

    // random traffic against the model
    p = 50;
    for (int i = 0; i < 2500; i++) begin
      if (i % 64 == 0) p = $urandom_range(0, 100);
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 99) < p));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
